// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcode/funct
// constants, ALU operation codes, PC source selects and decode helpers.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b111
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
                    default:                               ok = 1'b0;
                endcase
            end
            OP_ADDIU, OP_ORI, OP_SLTI, OP_LW, OP_SW,
            OP_BEQ, OP_BNE, OP_J, OP_HALT:               ok = 1'b1;
            default:                                     ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] alu_op_of(input logic [5:0] op, input logic [5:0] fn);
        logic [2:0] alu;
        alu = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_SUB:  alu = ALU_SUB;
                    FN_AND:  alu = ALU_AND;
                    FN_OR:   alu = ALU_OR;
                    FN_SLT:  alu = ALU_SLT;
                    default: alu = ALU_ADD;
                endcase
            end
            OP_ORI:          alu = ALU_OR;
            OP_SLTI:         alu = ALU_SLT;
            OP_BEQ, OP_BNE:  alu = ALU_SUB;
            default:         alu = ALU_ADD;
        endcase
        return alu;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_decode.sv
// mc_decode: combinational map of (state, opcode, funct, zero) to datapath
// controls and the next FSM state.
module mc_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6
) (
    input  logic [2:0]         i_state,
    input  logic [OP_W-1:0]    i_opcode,
    input  logic [FUNCT_W-1:0] i_funct,
    input  logic               i_zero,
    output logic [2:0]         o_next_state,
    output logic               o_pcwre,
    output logic               o_irwre,
    output logic               o_regwre,
    output logic               o_regdst,
    output logic               o_dbdatasrc,
    output logic               o_alusrcb,
    output logic               o_extsel,
    output logic [2:0]         o_aluop,
    output logic               o_mrd,
    output logic               o_mwr,
    output logic [1:0]         o_pcsrc,
    output logic               o_halted
);

    logic w_imm_s;
    logic w_sext_s;
    logic w_taken_s;

    // Instruction-class helpers shared by EXE, MEM and WB.
    always_comb begin
        w_imm_s   = (i_opcode == OP_ADDIU) || (i_opcode == OP_ORI) || (i_opcode == OP_SLTI) ||
                    (i_opcode == OP_LW)    || (i_opcode == OP_SW);
        w_sext_s  = (i_opcode == OP_ADDIU) || (i_opcode == OP_SLTI) || (i_opcode == OP_LW) ||
                    (i_opcode == OP_SW)    || (i_opcode == OP_BEQ)  || (i_opcode == OP_BNE);
        w_taken_s = ((i_opcode == OP_BEQ) && i_zero) || ((i_opcode == OP_BNE) && !i_zero);
    end

    // Per-state control decode; ALU controls stay valid from EXE through WB
    // so the unregistered ALU result is still correct at write-back.
    always_comb begin
        o_next_state = S_IF;
        o_pcwre      = 1'b0;
        o_irwre      = 1'b0;
        o_regwre     = 1'b0;
        o_regdst     = 1'b0;
        o_dbdatasrc  = 1'b0;
        o_alusrcb    = 1'b0;
        o_extsel     = 1'b0;
        o_aluop      = ALU_ADD;
        o_mrd        = 1'b0;
        o_mwr        = 1'b0;
        o_pcsrc      = PCSRC_SEQ;
        o_halted     = 1'b0;
        case (i_state)
            S_IF: begin
                o_irwre      = 1'b1;
                o_next_state = S_ID;
            end
            S_ID: begin
                if (i_opcode == OP_J) begin
                    o_pcsrc      = PCSRC_JMP;
                    o_pcwre      = 1'b1;
                    o_next_state = S_IF;
                end else if (i_opcode == OP_HALT) begin
                    o_next_state = S_HALT;
                end else if (!is_legal(i_opcode, i_funct)) begin
                    o_pcwre      = 1'b1;
                    o_next_state = S_IF;
                end else begin
                    o_next_state = S_EXE;
                end
            end
            S_EXE: begin
                o_aluop   = alu_op_of(i_opcode, i_funct);
                o_alusrcb = w_imm_s;
                o_extsel  = w_sext_s;
                if ((i_opcode == OP_BEQ) || (i_opcode == OP_BNE)) begin
                    o_pcwre      = 1'b1;
                    o_pcsrc      = w_taken_s ? PCSRC_BR : PCSRC_SEQ;
                    o_next_state = S_IF;
                end else if ((i_opcode == OP_LW) || (i_opcode == OP_SW)) begin
                    o_next_state = S_MEM;
                end else begin
                    o_next_state = S_WB;
                end
            end
            S_MEM: begin
                o_aluop   = alu_op_of(i_opcode, i_funct);
                o_alusrcb = w_imm_s;
                o_extsel  = w_sext_s;
                if (i_opcode == OP_LW) begin
                    o_mrd        = 1'b1;
                    o_next_state = S_WB;
                end else if (i_opcode == OP_SW) begin
                    o_mwr        = 1'b1;
                    o_pcwre      = 1'b1;
                    o_next_state = S_IF;
                end else begin
                    o_next_state = S_IF;
                end
            end
            S_WB: begin
                o_aluop      = alu_op_of(i_opcode, i_funct);
                o_alusrcb    = w_imm_s;
                o_extsel     = w_sext_s;
                o_regwre     = 1'b1;
                o_pcwre      = 1'b1;
                o_regdst     = (i_opcode == OP_RTYPE);
                o_dbdatasrc  = (i_opcode == OP_LW);
                o_next_state = S_IF;
            end
            S_HALT: begin
                o_halted     = 1'b1;
                o_next_state = S_HALT;
            end
            default: begin
                o_next_state = S_IF;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: state register plus optional performance
// counters (cycle_cnt/instr_cnt) enabled by defining PERF_CNT_EN.
module multicycle_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               zero,
    output logic               PCWre,
    output logic               IRWre,
    output logic               RegWre,
    output logic               RegDst,
    output logic               DBDataSrc,
    output logic               ALUSrcB,
    output logic               ExtSel,
    output logic [2:0]         ALUOp,
    output logic               mRD,
    output logic               mWR,
    output logic [1:0]         PCSrc,
    output logic [2:0]         state,
`ifdef PERF_CNT_EN
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        instr_cnt,
`endif
    output logic               halted
);

    state_e     r_state;
    logic [2:0] w_next_state;
    logic       w_pcwre, w_irwre, w_regwre, w_regdst, w_dbdatasrc;
    logic       w_alusrcb, w_extsel, w_mrd, w_mwr, w_halted;
    logic [2:0] w_aluop;
    logic [1:0] w_pcsrc;

    mc_decode #(
        .OP_W    (OP_W),
        .FUNCT_W (FUNCT_W)
    ) u_decode (
        .i_state      (r_state),
        .i_opcode     (opcode),
        .i_funct      (funct),
        .i_zero       (zero),
        .o_next_state (w_next_state),
        .o_pcwre      (w_pcwre),
        .o_irwre      (w_irwre),
        .o_regwre     (w_regwre),
        .o_regdst     (w_regdst),
        .o_dbdatasrc  (w_dbdatasrc),
        .o_alusrcb    (w_alusrcb),
        .o_extsel     (w_extsel),
        .o_aluop      (w_aluop),
        .o_mrd        (w_mrd),
        .o_mwr        (w_mwr),
        .o_pcsrc      (w_pcsrc),
        .o_halted     (w_halted)
    );

    // FSM state register; reset aborts any instruction in flight.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IF;
        end else begin
            r_state <= state_e'(w_next_state);
        end
    end

    // IF decodes IRWre=1, so every output is gated while Reset is held low.
    assign PCWre     = Reset & w_pcwre;
    assign IRWre     = Reset & w_irwre;
    assign RegWre    = Reset & w_regwre;
    assign RegDst    = Reset & w_regdst;
    assign DBDataSrc = Reset & w_dbdatasrc;
    assign ALUSrcB   = Reset & w_alusrcb;
    assign ExtSel    = Reset & w_extsel;
    assign ALUOp     = Reset ? w_aluop : 3'b000;
    assign mRD       = Reset & w_mrd;
    assign mWR       = Reset & w_mwr;
    assign PCSrc     = Reset ? w_pcsrc : 2'b00;
    assign state     = Reset ? r_state : 3'b000;
    assign halted    = Reset & w_halted;

`ifdef PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instr_cnt;

    // Performance counters; both wrap naturally at 32 bits.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_cycle_cnt <= 32'd0;
            r_instr_cnt <= 32'd0;
        end else begin
            if (r_state != S_HALT) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end else begin
                r_cycle_cnt <= r_cycle_cnt;
            end
            if (w_pcwre) begin
                r_instr_cnt <= r_instr_cnt + 32'd1;
            end else begin
                r_instr_cnt <= r_instr_cnt;
            end
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit; expected values
// are hand-derived per instruction class and state.
module tb_multicycle_control_unit;

    logic        CLK;
    logic        Reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        PCWre, IRWre, RegWre, RegDst, DBDataSrc, ALUSrcB, ExtSel;
    logic [2:0]  ALUOp;
    logic        mRD, mWR;
    logic [1:0]  PCSrc;
    logic [2:0]  state;
    logic        halted;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
    logic [31:0] cyc_snap;
    logic [31:0] ins_snap;
`endif

    int total;
    int bad;

    multicycle_control_unit dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .PCWre     (PCWre),
        .IRWre     (IRWre),
        .RegWre    (RegWre),
        .RegDst    (RegDst),
        .DBDataSrc (DBDataSrc),
        .ALUSrcB   (ALUSrcB),
        .ExtSel    (ExtSel),
        .ALUOp     (ALUOp),
        .mRD       (mRD),
        .mWR       (mWR),
        .PCSrc     (PCSrc),
        .state     (state),
`ifdef PERF_CNT_EN
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt),
`endif
        .halted    (halted)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // ALU-class table: opcode, funct, ALUOp, ALUSrcB, ExtSel, RegDst
    logic [5:0] t_op  [8] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h09, 6'h0D, 6'h0A};
    logic [5:0] t_fn  [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h00, 6'h00};
    logic [2:0] t_alu [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd3, 3'd4};
    logic       t_src [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       t_ext [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       t_dst [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // Branch table: opcode, zero, expected PCSrc in EXE
    logic [5:0] b_op  [4] = '{6'h04, 6'h04, 6'h05, 6'h05};
    logic       b_z   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0] b_src [4] = '{2'b01, 2'b00, 2'b00, 2'b01};

    initial begin
        total  = 0;
        bad    = 0;
        Reset  = 1'b0;
        opcode = 6'h00;
        funct  = 6'h20;
        zero   = 1'b0;

        #3;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_irwre", 32'(IRWre), 32'd0);
        chk("rst_pcwre", 32'(PCWre), 32'd0);
        #5;
        Reset = 1'b1;
        #1;
        chk("post_rst_irwre", 32'(IRWre), 32'd1);
        chk("post_rst_state", 32'(state), 32'd0);

        for (int i = 0; i < 8; i++) begin
            opcode = t_op[i];
            funct  = t_fn[i];
            step();
            chk($sformatf("alu%0d_id_state", i), 32'(state), 32'd1);
            chk($sformatf("alu%0d_id_pcwre", i), 32'(PCWre), 32'd0);
            step();
            chk($sformatf("alu%0d_exe_state", i), 32'(state), 32'd2);
            chk($sformatf("alu%0d_exe_aluop", i), 32'(ALUOp), 32'(t_alu[i]));
            chk($sformatf("alu%0d_exe_srcb", i), 32'(ALUSrcB), 32'(t_src[i]));
            chk($sformatf("alu%0d_exe_ext", i), 32'(ExtSel), 32'(t_ext[i]));
            chk($sformatf("alu%0d_exe_regwre", i), 32'(RegWre), 32'd0);
            step();
            chk($sformatf("alu%0d_wb_state", i), 32'(state), 32'd4);
            chk($sformatf("alu%0d_wb_regwre", i), 32'(RegWre), 32'd1);
            chk($sformatf("alu%0d_wb_regdst", i), 32'(RegDst), 32'(t_dst[i]));
            chk($sformatf("alu%0d_wb_dbsrc", i), 32'(DBDataSrc), 32'd0);
            chk($sformatf("alu%0d_wb_aluop", i), 32'(ALUOp), 32'(t_alu[i]));
            chk($sformatf("alu%0d_wb_pcwre", i), 32'(PCWre), 32'd1);
            chk($sformatf("alu%0d_wb_pcsrc", i), 32'(PCSrc), 32'd0);
            step();
            chk($sformatf("alu%0d_if_state", i), 32'(state), 32'd0);
            chk($sformatf("alu%0d_if_irwre", i), 32'(IRWre), 32'd1);
        end

        opcode = 6'h23;
        funct  = 6'h00;
        step();
        chk("lw_id_mrd", 32'(mRD), 32'd0);
        step();
        chk("lw_exe_ext", 32'(ExtSel), 32'd1);
        chk("lw_exe_srcb", 32'(ALUSrcB), 32'd1);
        chk("lw_exe_aluop", 32'(ALUOp), 32'd0);
        chk("lw_exe_mrd", 32'(mRD), 32'd0);
        chk("lw_exe_pcwre", 32'(PCWre), 32'd0);
        step();
        chk("lw_mem_state", 32'(state), 32'd3);
        chk("lw_mem_mrd", 32'(mRD), 32'd1);
        chk("lw_mem_mwr", 32'(mWR), 32'd0);
        chk("lw_mem_regwre", 32'(RegWre), 32'd0);
        chk("lw_mem_pcwre", 32'(PCWre), 32'd0);
        step();
        chk("lw_wb_state", 32'(state), 32'd4);
        chk("lw_wb_mrd", 32'(mRD), 32'd0);
        chk("lw_wb_dbsrc", 32'(DBDataSrc), 32'd1);
        chk("lw_wb_regdst", 32'(RegDst), 32'd0);
        chk("lw_wb_regwre", 32'(RegWre), 32'd1);
        step();
        chk("lw_if_state", 32'(state), 32'd0);

        opcode = 6'h2B;
        step();
        step();
        chk("sw_exe_ext", 32'(ExtSel), 32'd1);
        step();
        chk("sw_mem_state", 32'(state), 32'd3);
        chk("sw_mem_mwr", 32'(mWR), 32'd1);
        chk("sw_mem_mrd", 32'(mRD), 32'd0);
        chk("sw_mem_pcwre", 32'(PCWre), 32'd1);
        chk("sw_mem_regwre", 32'(RegWre), 32'd0);
        step();
        chk("sw_if_state", 32'(state), 32'd0);

        for (int i = 0; i < 4; i++) begin
            opcode = b_op[i];
            zero   = b_z[i];
            step();
            chk($sformatf("br%0d_id_regwre", i), 32'(RegWre), 32'd0);
            step();
            chk($sformatf("br%0d_exe_state", i), 32'(state), 32'd2);
            chk($sformatf("br%0d_exe_pcsrc", i), 32'(PCSrc), 32'(b_src[i]));
            chk($sformatf("br%0d_exe_pcwre", i), 32'(PCWre), 32'd1);
            chk($sformatf("br%0d_exe_aluop", i), 32'(ALUOp), 32'd1);
            chk($sformatf("br%0d_exe_ext", i), 32'(ExtSel), 32'd1);
            chk($sformatf("br%0d_exe_regwre", i), 32'(RegWre), 32'd0);
            step();
            chk($sformatf("br%0d_if_state", i), 32'(state), 32'd0);
        end
        zero = 1'b0;

        opcode = 6'h02;
        step();
        chk("j_id_pcsrc", 32'(PCSrc), 32'd2);
        chk("j_id_pcwre", 32'(PCWre), 32'd1);
        step();
        chk("j_if_state", 32'(state), 32'd0);

        opcode = 6'h33;
        step();
        chk("undef_id_pcwre", 32'(PCWre), 32'd1);
        chk("undef_id_pcsrc", 32'(PCSrc), 32'd0);
        step();
        chk("undef_if_state", 32'(state), 32'd0);

        opcode = 6'h00;
        funct  = 6'h00;
        step();
        chk("badfn_id_pcwre", 32'(PCWre), 32'd1);
        step();
        chk("badfn_if_state", 32'(state), 32'd0);

        opcode = 6'h23;
        step();
        step();
        chk("abort_exe_state", 32'(state), 32'd2);
        #2;
        Reset = 1'b0;
        #1;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_mrd", 32'(mRD), 32'd0);
        chk("abort_regwre", 32'(RegWre), 32'd0);
        chk("abort_irwre", 32'(IRWre), 32'd0);
        #3;
        Reset = 1'b1;
        #1;
        chk("rerun_irwre", 32'(IRWre), 32'd1);
        step();
        chk("rerun_id_state", 32'(state), 32'd1);
        step();
        step();
        step();
        step();
        chk("rerun_if_state", 32'(state), 32'd0);

        opcode = 6'h3F;
        step();
        step();
        chk("halt_state", 32'(state), 32'd7);
        chk("halt_flag", 32'(halted), 32'd1);
`ifdef PERF_CNT_EN
        cyc_snap = cycle_cnt;
        ins_snap = instr_cnt;
`endif
        for (int k = 0; k < 22; k++) begin
            step();
            total++;
            assert (state === 3'd7 && halted === 1'b1 && PCWre === 1'b0 && IRWre === 1'b0 &&
                    RegWre === 1'b0 && mRD === 1'b0 && mWR === 1'b0) else begin
                bad++;
                $error("FAIL halt_hold%0d: observed state=%0d halted=%0b en=%0b%0b%0b%0b%0b expected state=7 halted=1 en=00000",
                       k, state, halted, PCWre, IRWre, RegWre, mRD, mWR);
            end
        end
`ifdef PERF_CNT_EN
        chk("halt_cycle_frozen", cycle_cnt, cyc_snap);
        chk("halt_instr_frozen", instr_cnt, ins_snap);
`endif
        #3;
        Reset = 1'b0;
        #1;
        chk("halt_exit_state", 32'(state), 32'd0);
        chk("halt_exit_flag", 32'(halted), 32'd0);
`ifdef PERF_CNT_EN
        chk("perf_rst_cycle", cycle_cnt, 32'd0);
        chk("perf_rst_instr", instr_cnt, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
